// File: rtl/intrapred_stream_pkg.sv
// Shared definitions for the intra-prediction residual stream: mode codes,
// controller states and the SAD accumulator width.
package intrapred_pkg;

  typedef enum logic [1:0] {
    MODE_V  = 2'd0,
    MODE_H  = 2'd1,
    MODE_DC = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DECIDE,
    S_EMIT
  } state_e;

  // A whole block of worst-case differences fits without wrap.
  function automatic int unsigned sad_width(input int unsigned bitdepth,
                                            input int unsigned blk);
    return bitdepth + 2 * $clog2(blk);
  endfunction

endpackage

// File: rtl/intrapred_stream_if.sv
// Block-start command, original-row input stream and residual-row output stream.
interface intrapred_stream_if
  import intrapred_pkg::*;
#(
  parameter int BLK      = 8,
  parameter int BITDEPTH = 8
);
  localparam int SADW = sad_width(BITDEPTH, BLK);

  logic                             start;
  logic [BLK-1:0][BITDEPTH-1:0]     top;
  logic [BLK-1:0][BITDEPTH-1:0]     left;
  logic                             top_avail;
  logic                             left_avail;

  logic                             in_valid;
  logic                             in_ready;
  logic [BLK-1:0][BITDEPTH-1:0]     in_row;

  logic                             out_valid;
  logic                             out_ready;
  logic [BLK-1:0][BITDEPTH:0]       out_row;
  logic                             out_last;
  logic [1:0]                       out_mode;
  logic [SADW-1:0]                  out_sad;
  logic                             busy;

  modport master (
    output start, top, left, top_avail, left_avail, in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_last, out_mode, out_sad, busy
  );

  modport slave (
    input  start, top, left, top_avail, left_avail, in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_last, out_mode, out_sad, busy
  );
endinterface

// File: rtl/intrapred_stream_absdiff_row.sv
// Sum of absolute differences between one original row and one prediction row.
module absdiff_row #(
  parameter int BLK      = 8,
  parameter int BITDEPTH = 8
) (
  input  logic [BLK-1:0][BITDEPTH-1:0]       row_i,
  input  logic [BLK-1:0][BITDEPTH-1:0]       pred_i,
  output logic [BITDEPTH+$clog2(BLK)-1:0]    sad_o
);
  localparam int SUMW = BITDEPTH + $clog2(BLK);

  always_comb begin
    sad_o = '0;
    for (int unsigned c = 0; c < BLK; c++) begin
      sad_o = sad_o + SUMW'((row_i[c] >= pred_i[c]) ? (row_i[c] - pred_i[c])
                                                     : (pred_i[c] - row_i[c]));
    end
  end
endmodule

// File: rtl/intrapred_stream.sv
// Intra-prediction mode decision (V/H/DC) over a streamed block, followed by
// streaming of the residual rows for the winning mode.
module intrapred_stream
  import intrapred_pkg::*;
#(
  parameter int BLK      = 8,
  parameter int BITDEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  intrapred_stream_if.slave bus
);
  localparam int RW   = $clog2(BLK);
  localparam int SADW = sad_width(BITDEPTH, BLK);
  localparam int RSW  = BITDEPTH + $clog2(BLK);
  localparam int DCW  = BITDEPTH + $clog2(BLK) + 2;

  typedef logic [BLK-1:0][BITDEPTH-1:0] row_t;

  state_e          state_q, state_d;
  row_t            top_q, left_q;
  logic            top_av_q, left_av_q, first_q;
  logic [RW-1:0]   row_q;
  logic [BITDEPTH-1:0] dc_q, dc_c;
  logic [SADW-1:0] sad_q [3];
  logic [SADW-1:0] out_sad_q, best_sad;
  mode_e           mode_q, best_mode;
  row_t            buf_q [BLK];
  row_t            pred_v, pred_h, pred_dc;
  logic [RSW-1:0]  rs_v, rs_h, rs_dc;
  logic            in_ready_c, in_hs, out_hs, last_row;
  logic [DCW-1:0]  sum_t, sum_l;
  logic [BLK-1:0][BITDEPTH:0] res_c;
  logic [BITDEPTH-1:0] p;
  row_t            emit_row;

  assign in_ready_c = (state_q == S_LOAD);
  assign in_hs      = bus.in_valid && in_ready_c;
  assign out_hs     = (state_q == S_EMIT) && bus.out_ready;
  assign last_row   = (row_q == RW'(BLK - 1));

  // DC from the latched edges; stable for the whole block once latched.
  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int unsigned c = 0; c < BLK; c++) begin
      sum_t = sum_t + DCW'(top_q[c]);
      sum_l = sum_l + DCW'(left_q[c]);
    end
    if (top_av_q && left_av_q)
      dc_c = BITDEPTH'((sum_t + sum_l + DCW'(BLK)) >> $clog2(2 * BLK));
    else if (top_av_q)
      dc_c = BITDEPTH'((sum_t + DCW'(BLK / 2)) >> $clog2(BLK));
    else if (left_av_q)
      dc_c = BITDEPTH'((sum_l + DCW'(BLK / 2)) >> $clog2(BLK));
    else
      dc_c = BITDEPTH'(1) << (BITDEPTH - 1);
  end

  assign pred_v  = top_q;
  assign pred_h  = {BLK{left_q[row_q]}};
  assign pred_dc = {BLK{dc_c}};

  absdiff_row #(.BLK(BLK), .BITDEPTH(BITDEPTH)) u_sad_v
    (.row_i(bus.in_row), .pred_i(pred_v),  .sad_o(rs_v));
  absdiff_row #(.BLK(BLK), .BITDEPTH(BITDEPTH)) u_sad_h
    (.row_i(bus.in_row), .pred_i(pred_h),  .sad_o(rs_h));
  absdiff_row #(.BLK(BLK), .BITDEPTH(BITDEPTH)) u_sad_dc
    (.row_i(bus.in_row), .pred_i(pred_dc), .sad_o(rs_dc));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start)          state_d = S_LOAD;
      S_LOAD:   if (in_hs && last_row)  state_d = S_DECIDE;
      S_DECIDE:                         state_d = S_EMIT;
      S_EMIT:   if (out_hs && last_row) state_d = S_IDLE;
    endcase
  end

  // Checked from DC upward with <= so the lower mode index wins ties.
  always_comb begin
    best_mode = MODE_DC;
    best_sad  = sad_q[2];
    if (left_av_q && (sad_q[1] <= best_sad)) begin
      best_mode = MODE_H;
      best_sad  = sad_q[1];
    end
    if (top_av_q && (sad_q[0] <= best_sad)) begin
      best_mode = MODE_V;
      best_sad  = sad_q[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q     <= '0;
      left_q    <= '0;
      top_av_q  <= 1'b0;
      left_av_q <= 1'b0;
      first_q   <= 1'b0;
      row_q     <= '0;
      dc_q      <= '0;
      sad_q     <= '{default: '0};
      out_sad_q <= '0;
      mode_q    <= MODE_V;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          top_q     <= bus.top;
          left_q    <= bus.left;
          top_av_q  <= bus.top_avail;
          left_av_q <= bus.left_avail;
          first_q   <= 1'b1;
          row_q     <= '0;
          sad_q     <= '{default: '0};
        end
        S_LOAD: begin
          first_q <= 1'b0;
          if (first_q) dc_q <= dc_c;
          if (in_hs) begin
            row_q    <= row_q + 1'b1;
            sad_q[0] <= sad_q[0] + SADW'(rs_v);
            sad_q[1] <= sad_q[1] + SADW'(rs_h);
            sad_q[2] <= sad_q[2] + SADW'(rs_dc);
          end
        end
        S_DECIDE: begin
          mode_q    <= best_mode;
          out_sad_q <= best_sad;
          row_q     <= '0;
        end
        S_EMIT: if (out_hs) row_q <= row_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) buf_q[row_q] <= bus.in_row;
  end

  assign emit_row = buf_q[row_q];

  always_comb begin
    res_c = '0;
    p     = '0;
    for (int unsigned c = 0; c < BLK; c++) begin
      case (mode_q)
        MODE_V:  p = top_q[c];
        MODE_H:  p = left_q[row_q];
        default: p = dc_q;
      endcase
      res_c[c] = {1'b0, emit_row[c]} - {1'b0, p};
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_row   = (state_q == S_EMIT) ? res_c : '0;
  assign bus.out_last  = (state_q == S_EMIT) && last_row;
  assign bus.out_mode  = mode_q;
  assign bus.out_sad   = out_sad_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_intrapred_stream.sv
// Randomized and directed bench for intrapred_stream with an array-based model.
module tb_intrapred_stream;
  import intrapred_pkg::*;

  localparam int BLK = 4;
  localparam int BD  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intrapred_stream_if #(.BLK(BLK), .BITDEPTH(BD)) ifc();

  intrapred_stream #(.BLK(BLK), .BITDEPTH(BD)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model inputs/outputs
  int m_top [BLK];
  int m_left[BLK];
  int m_orig[BLK*BLK];
  bit m_ta, m_la;
  int m_mode, m_sad, m_dc;
  int m_res [BLK*BLK];

  int exp_mode[$];
  int exp_sad [$];
  int exp_res [$];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int pred_of(input int m, input int r, input int c);
    if (m == 0) return m_top[c];
    if (m == 1) return m_left[r];
    return m_dc;
  endfunction

  function void run_model();
    int st, sl;
    int s[3];
    bit elig;
    st = 0; sl = 0;
    for (int i = 0; i < BLK; i++) begin st += m_top[i]; sl += m_left[i]; end
    if (m_ta && m_la)  m_dc = (st + sl + BLK) / (2 * BLK);
    else if (m_ta)     m_dc = (st + BLK / 2) / BLK;
    else if (m_la)     m_dc = (sl + BLK / 2) / BLK;
    else               m_dc = 1 << (BD - 1);
    for (int m = 0; m < 3; m++) begin
      s[m] = 0;
      for (int r = 0; r < BLK; r++)
        for (int c = 0; c < BLK; c++)
          s[m] += iabs(m_orig[r*BLK+c] - pred_of(m, r, c));
    end
    m_mode = -1;
    m_sad  = 0;
    for (int m = 0; m < 3; m++) begin
      elig = (m == 2) || (m == 0 && m_ta) || (m == 1 && m_la);
      if (elig && (m_mode < 0 || s[m] < m_sad)) begin
        m_mode = m;
        m_sad  = s[m];
      end
    end
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        m_res[r*BLK+c] = m_orig[r*BLK+c] - pred_of(m_mode, r, c);
  endfunction

  // Output monitor / scoreboard
  int  mon_row = 0;
  bit  prev_stall = 0;
  logic [BLK-1:0][BD:0] prev_row, er;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_row    = 0;
      prev_stall = 0;
    end else if (ifc.out_valid) begin
      if (exp_mode.size() == 0) begin
        check("out_valid_unexpected", ifc.out_valid, 0);
      end else begin
        for (int c = 0; c < BLK; c++) er[c] = 9'(exp_res[mon_row*BLK+c]);
        check("out_row", ifc.out_row, er);
        check("out_mode", ifc.out_mode, exp_mode[0]);
        check("out_sad", ifc.out_sad, exp_sad[0]);
        check("out_last", ifc.out_last, mon_row == BLK - 1);
        if (prev_stall) check("stall_hold", ifc.out_row, prev_row);
        prev_stall = !ifc.out_ready;
        prev_row   = ifc.out_row;
        if (ifc.out_ready) begin
          if (mon_row == BLK - 1) begin
            void'(exp_mode.pop_front());
            void'(exp_sad.pop_front());
            for (int i = 0; i < BLK*BLK; i++) void'(exp_res.pop_front());
            mon_row = 0;
          end else begin
            mon_row++;
          end
        end
      end
    end else begin
      prev_stall = 0;
    end
  end

  // out_ready driver: 0 always ready, 1 random, 2 three-cycle stall on row 1
  int rdy_mode = 0;
  int stall_n  = 0;
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ifc.out_ready = 1'b1;
        1: ifc.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (ifc.out_valid && mon_row == 1 && stall_n < 3) begin
            ifc.out_ready = 1'b0;
            stall_n++;
          end else begin
            ifc.out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (ifc.busy && k < 300) begin @(negedge clk); k++; end
    check("idle_timeout", ifc.busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic start_block(input bit push);
    for (int c = 0; c < BLK; c++) begin
      ifc.top[c]  = 8'(m_top[c]);
      ifc.left[c] = 8'(m_left[c]);
    end
    ifc.top_avail  = m_ta;
    ifc.left_avail = m_la;
    ifc.start      = 1'b1;
    if (push) begin
      run_model();
      exp_mode.push_back(m_mode);
      exp_sad.push_back(m_sad);
      for (int i = 0; i < BLK*BLK; i++) exp_res.push_back(m_res[i]);
    end
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic send_rows(input int n, input bit gaps);
    int k;
    bit hs;
    for (int r = 0; r < n; r++) begin
      if (gaps) begin
        ifc.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      ifc.in_valid = 1'b1;
      for (int c = 0; c < BLK; c++) ifc.in_row[c] = 8'(m_orig[r*BLK+c]);
      k  = 0;
      hs = 0;
      while (!hs && k < 50) begin
        @(negedge clk); hs = ifc.in_ready;
        @(posedge clk); #1; k++;
      end
      check("in_handshake", hs, 1);
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic run_block(input bit gaps);
    start_block(1);
    send_rows(BLK, gaps);
    @(negedge clk); check("latency_decide", ifc.out_valid, 0);
    @(negedge clk); check("latency_emit", ifc.out_valid, 1);
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_last", ifc.out_last, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_out_mode", ifc.out_mode, 0);
    check("rst_out_sad", ifc.out_sad, 0);
    check("rst_out_row", ifc.out_row, 0);
  endtask

  task automatic gen_random();
    int style, v;
    for (int c = 0; c < BLK; c++) begin
      m_top[c]  = $urandom_range(0, 255);
      m_left[c] = $urandom_range(0, 255);
    end
    m_ta  = 1'($urandom_range(0, 1));
    m_la  = 1'($urandom_range(0, 1));
    style = $urandom_range(0, 2);
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++) begin
        if (style == 0) v = $urandom_range(0, 255);
        else if (style == 1) v = m_top[c] + $urandom_range(0, 6) - 3;
        else v = m_left[r] + $urandom_range(0, 6) - 3;
        m_orig[r*BLK+c] = (v < 0) ? 0 : (v > 255) ? 255 : v;
      end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.start = 0; ifc.top = '0; ifc.left = '0; ifc.top_avail = 0; ifc.left_avail = 0;
    ifc.in_valid = 0; ifc.in_row = '0;
    repeat (3) @(posedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vertical prediction exact
    for (int i = 0; i < BLK; i++) begin m_top[i] = 10; m_left[i] = 20; end
    for (int i = 0; i < BLK*BLK; i++) m_orig[i] = 10;
    m_ta = 1; m_la = 1;
    run_block(0);
    check("model_dc_v", m_dc, 15);
    check("model_mode_v", m_mode, 0);
    check("dut_mode_v", ifc.out_mode, 0);
    check("dut_sad_v", ifc.out_sad, 0);

    // Horizontal prediction exact
    for (int i = 0; i < BLK; i++) begin m_top[i] = 100; m_left[i] = 5 + i; end
    for (int r = 0; r < BLK; r++) for (int c = 0; c < BLK; c++) m_orig[r*BLK+c] = 5 + r;
    run_block(0);
    check("model_mode_h", m_mode, 1);
    check("dut_mode_h", ifc.out_mode, 1);
    check("dut_sad_h", ifc.out_sad, 0);

    // No edges: DC midpoint
    for (int i = 0; i < BLK; i++) begin m_top[i] = 0; m_left[i] = 0; end
    for (int i = 0; i < BLK*BLK; i++) m_orig[i] = 128;
    m_ta = 0; m_la = 0;
    run_block(0);
    check("model_dc_none", m_dc, 128);
    check("dut_mode_dc", ifc.out_mode, 2);
    check("dut_sad_dc", ifc.out_sad, 0);

    // Three-way tie
    for (int i = 0; i < BLK; i++) begin m_top[i] = 50; m_left[i] = 50; end
    for (int i = 0; i < BLK*BLK; i++) m_orig[i] = 50;
    m_ta = 1; m_la = 1;
    run_block(0);
    check("dut_mode_tie", ifc.out_mode, 0);
    check("dut_sad_tie", ifc.out_sad, 0);

    // Backpressure during residual row 1
    gen_random();
    for (int i = 0; i < BLK*BLK; i++) m_orig[i] = i * 13;
    rdy_mode = 2; stall_n = 0;
    run_block(0);
    check("stall_cycles", stall_n, 3);
    rdy_mode = 0;

    // Reset in the middle of LOAD, then a fresh block
    gen_random();
    start_block(0);
    send_rows(2, 0);
    rst_n = 1'b0;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    gen_random();
    run_block(0);
    check("post_reset_mode", ifc.out_mode, m_mode);

    // Randomized blocks with input gaps and output backpressure
    rdy_mode = 1;
    for (int b = 0; b < 30; b++) begin
      gen_random();
      run_block(1);
    end
    rdy_mode = 0;
    wait_idle();
    check("pending_blocks", exp_mode.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intrapred_stream.md
INTRAPRED_STREAM -- requirements
Module: intrapred_stream

Interface
REQ-001 SHALL have parameter BLK, default 8, meaning block edge in pixels; legal values 4, 8, 16.
REQ-002 SHALL have parameter BITDEPTH, default 8, meaning sample width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports start (in, 1), top (in, BLK x BITDEPTH), left (in, BLK x BITDEPTH), top_avail (in, 1) and left_avail (in, 1); together these form the block-start command.
REQ-006 SHALL have ports in_valid (in, 1), in_ready (out, 1) and in_row (in, BLK x BITDEPTH); these carry the original-block rows, top row first.
REQ-007 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_row (out, BLK x signed BITDEPTH+1) and out_last (out, 1); these carry the residual rows.
REQ-008 SHALL have ports out_mode (out, 2) and out_sad (out, BITDEPTH+2*log2(BLK)); both give the chosen mode and its SAD.
REQ-009 SHALL have port busy (out, 1), which is high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, LOAD, DECIDE, EMIT.
REQ-011 In IDLE, start SHALL register top, left, top_avail, left_avail, clear the SAD accumulators and the row counter, and move to LOAD; start SHALL be ignored in any other state.
REQ-012 Modes SHALL be encoded as V=0, H=1, DC=2; value 3 is unused.
REQ-013 The V prediction SHALL be pred[r][c]=top[c]; the H prediction SHALL be pred[r][c]=left[r].
REQ-014 When both edges are available, DC SHALL be (sum top + sum left + BLK) >> log2(2*BLK).
REQ-015 When only one edge is available, DC SHALL be (sum of that edge + BLK/2) >> log2(BLK).
REQ-016 When no edge is available, DC SHALL be 1<<(BITDEPTH-1).
REQ-017 The DC value SHALL be computed and registered in the first LOAD cycle.
REQ-018 in_ready SHALL be high only in LOAD; each in_valid&&in_ready handshake SHALL store the row into an internal BLK x BLK buffer and add its row SAD to all three accumulators.
REQ-019 After BLK rows have been accepted, the block SHALL move to DECIDE.
REQ-020 DECIDE SHALL last one cycle and SHALL select the minimum-SAD mode among the eligible modes.
REQ-021 V SHALL be eligible only if top_avail=1, H only if left_avail=1, and DC always.
REQ-022 On equal SADs, the lowest mode index SHALL win.
REQ-023 out_mode and out_sad SHALL be updated at the DECIDE-to-EMIT transition and held until the next DECIDE.
REQ-024 In EMIT, out_valid SHALL be high, and out_row SHALL be orig minus pred of the chosen mode, sign-extended to BITDEPTH+1 bits, with no clipping.
REQ-025 The EMIT row index SHALL advance only on out_valid&&out_ready; out_row and out_last SHALL stay stable while out_valid&&!out_ready.
REQ-026 out_last SHALL be high on row BLK-1; its handshake SHALL return the block to IDLE.
REQ-027 The first out_valid SHALL occur 2 cycles after the handshake of the last input row.
REQ-028 SAD arithmetic SHALL be unsigned and wide enough that it never overflows for BITDEPTH and BLK.

Reset
REQ-029 Reset SHALL force state IDLE.
REQ-030 Reset SHALL drive in_ready, out_valid, out_last and busy to 0, out_mode to 0, out_sad to 0 and out_row to all zeros.
REQ-031 Reset SHALL clear the row counter and all accumulators; the row buffer contents are don't-care.
REQ-032 Reset asserted mid-LOAD or mid-EMIT SHALL discard the block; the first start after reset SHALL behave as a fresh block.

Structure
REQ-033 Package intrapred_pkg SHALL hold the mode encoding, the state enumeration and the SAD-width function.
REQ-034 Sub-module absdiff_row SHALL compute the BLK-wide sum of absolute differences between one row and one prediction row; it SHALL be instantiated once per mode.

Verification
REQ-035 BLK=4, top=10 x4, left=20 x4, both available, orig all 10: bench SHALL see out_mode=0, out_sad=0 and all residuals 0.
REQ-036 BLK=4, left={5,6,7,8}, top=100 x4, row r all left[r]: bench SHALL see out_mode=1 and out_sad=0.
REQ-037 BLK=4, no edges available, orig all 128: bench SHALL see out_mode=2, out_sad=0, with V and H never selected.
REQ-038 BLK=4, top=left=50, orig all 50: bench SHALL see a three-way tie resolve to out_mode=0.
REQ-039 out_ready low for 3 cycles during residual row 1: bench SHALL see out_row held stable, rows delivered in order 0..3, and out_last only on row 3.
REQ-040 reset asserted after 2 rows accepted: bench SHALL see all outputs at reset values and busy=0, and a following start plus 4 rows SHALL give correct results.
